// File: rtl/exc_ctrl_pkg.sv
// Shared exception codes, FSM encoding and default exception vector
// for the MEM-stage exception arbiter.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_TYPE_NONE = 32'h0;
  localparam logic [31:0] EXC_TYPE_INT  = 32'h1;
  localparam logic [31:0] EXC_TYPE_ADEL = 32'h4;
  localparam logic [31:0] EXC_TYPE_ADES = 32'h5;
  localparam logic [31:0] EXC_TYPE_SYS  = 32'h8;
  localparam logic [31:0] EXC_TYPE_BP   = 32'h9;
  localparam logic [31:0] EXC_TYPE_RI   = 32'ha;
  localparam logic [31:0] EXC_TYPE_OV   = 32'hc;
  localparam logic [31:0] EXC_TYPE_ERET = 32'he;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Multi-flop synchroniser for the asynchronous hardware interrupt lines.
module int_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int W           = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception arbiter: picks the highest-priority exception, holds it
// across SRAM stalls and commits it to CP0 with a one-cycle flush/redirect.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic        inst_adel_i,
  input  logic        ri_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        ov_i,
  input  logic        data_adel_i,
  input  logic        data_ades_i,
  input  logic        eret_i,
  input  logic [31:0] mem_addr_i,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic        cp0_en_o,
  output logic [31:0] except_type_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] badvaddr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  logic [5:0]  int_sync_w;
  logic [5:0]  hw_w;
  logic [7:0]  pend_w;
  logic        int_req_w;
  logic        exc_w;
  logic [31:0] type_c;
  logic [31:0] badv_c;

  state_e      state_q, state_d;
  logic        snap_ld;
  logic [31:0] snap_type_q, snap_pc_q, snap_badv_q;
  logic        snap_ds_q;
  logic [31:0] com_type_q, com_pc_q, com_badv_q;
  logic        com_ds_q;
  logic        in_commit;

  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                             cp0_cause_i[31:10], cp0_cause_i[7:0]};

  int_sync #(.SYNC_STAGES(SYNC_STAGES), .W(6)) u_int_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (int_i),
    .sync_o  (int_sync_w)
  );

  // Timer interrupt is already synchronous, so it joins after the chain.
  assign hw_w      = {int_sync_w[5] | timer_int_i, int_sync_w[4:0]};
  assign pend_w    = {hw_w, cp0_cause_i[9:8]} & cp0_status_i[15:8];
  assign int_req_w = (|pend_w) & cp0_status_i[0] & ~cp0_status_i[1];

  assign exc_w = valid_i & (int_req_w | inst_adel_i | ri_i | syscall_i | break_i |
                            ov_i | data_adel_i | data_ades_i | eret_i);

  always_comb begin
    type_c = EXC_TYPE_NONE;
    badv_c = '0;
    if (int_req_w)        type_c = EXC_TYPE_INT;
    else if (inst_adel_i) begin type_c = EXC_TYPE_ADEL; badv_c = pc_i; end
    else if (ri_i)        type_c = EXC_TYPE_RI;
    else if (syscall_i)   type_c = EXC_TYPE_SYS;
    else if (break_i)     type_c = EXC_TYPE_BP;
    else if (ov_i)        type_c = EXC_TYPE_OV;
    else if (data_adel_i) begin type_c = EXC_TYPE_ADEL; badv_c = mem_addr_i; end
    else if (data_ades_i) begin type_c = EXC_TYPE_ADES; badv_c = mem_addr_i; end
    else if (eret_i)      type_c = EXC_TYPE_ERET;
  end

  always_comb begin
    state_d = state_q;
    snap_ld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exc_w) begin
          snap_ld = 1'b1;
          state_d = stall_i ? ST_PEND : ST_COMMIT;
        end
      end
      ST_PEND:   if (!stall_i) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Snapshot stage: only observable in COMMIT, which reset always leaves.
  always_ff @(posedge clk) begin
    if (snap_ld) begin
      snap_type_q <= type_c;
      snap_pc_q   <= pc_i;
      snap_ds_q   <= is_in_delayslot_i;
      snap_badv_q <= badv_c;
    end
  end

  assign in_commit = (state_q == ST_COMMIT);

  // Committed stage: CP0-facing fields persist until the next commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      com_type_q <= '0;
      com_pc_q   <= '0;
      com_ds_q   <= 1'b0;
      com_badv_q <= '0;
    end else if (in_commit) begin
      com_type_q <= snap_type_q;
      com_pc_q   <= snap_pc_q;
      com_ds_q   <= snap_ds_q;
      com_badv_q <= snap_badv_q;
    end
  end

  assign cp0_en_o            = in_commit;
  assign flush_o             = in_commit;
  assign except_type_o       = in_commit ? snap_type_q : com_type_q;
  assign current_inst_addr_o = in_commit ? snap_pc_q   : com_pc_q;
  assign is_in_delayslot_o   = in_commit ? snap_ds_q   : com_ds_q;
  assign badvaddr_o          = in_commit ? snap_badv_q : com_badv_q;
  assign new_pc_o = !in_commit                    ? 32'h0 :
                    (snap_type_q == EXC_TYPE_ERET) ? cp0_epc_i : EXC_VECTOR;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed-vector bench for exc_ctrl with hand-computed expectations.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_i, is_in_delayslot_i;
  logic [31:0] pc_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        inst_adel_i, ri_i, syscall_i, break_i, ov_i;
  logic        data_adel_i, data_ades_i, eret_i, timer_int_i;
  logic [5:0]  int_i;
  logic        cp0_en_o, is_in_delayslot_o, flush_o;
  logic [31:0] except_type_o, current_inst_addr_o, badvaddr_o, new_pc_o;

  int n_chk  = 0;
  int n_pass = 0;
  int lat;
  int seen;

  exc_ctrl #(.EXC_VECTOR(32'hBFC0_0380), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i), .inst_adel_i(inst_adel_i), .ri_i(ri_i),
    .syscall_i(syscall_i), .break_i(break_i), .ov_i(ov_i),
    .data_adel_i(data_adel_i), .data_ades_i(data_ades_i), .eret_i(eret_i),
    .mem_addr_i(mem_addr_i), .int_i(int_i), .timer_int_i(timer_int_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .cp0_en_o(cp0_en_o), .except_type_o(except_type_o),
    .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
    .badvaddr_o(badvaddr_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid_i = 0; is_in_delayslot_i = 0; inst_adel_i = 0; ri_i = 0; syscall_i = 0;
    break_i = 0; ov_i = 0; data_adel_i = 0; data_ades_i = 0; eret_i = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    {31'h0, cp0_en_o}, 32'h0);
    chk({tag, "_flush"}, {31'h0, flush_o}, 32'h0);
    chk({tag, "_type"},  except_type_o, 32'h0);
    chk({tag, "_pc"},    current_inst_addr_o, 32'h0);
    chk({tag, "_ds"},    {31'h0, is_in_delayslot_o}, 32'h0);
    chk({tag, "_badv"},  badvaddr_o, 32'h0);
    chk({tag, "_npc"},   new_pc_o, 32'h0);
  endtask

  initial begin
    rst = 1; stall_i = 0; pc_i = 0; mem_addr_i = 0; int_i = 0; timer_int_i = 0;
    cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    clr();
    step(); step();
    chk_all_zero("rst");
    rst = 0;
    step();

    // Hardware interrupt through the synchroniser
    cp0_status_i = 32'h0000_0401; int_i = 6'h01; valid_i = 1; pc_i = 32'h0000_1000;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (cp0_en_o) begin lat = k; break; end
    end
    chk("int_latency", lat, 3);
    chk("int_type", except_type_o, 32'h1);
    chk("int_npc", new_pc_o, 32'hBFC0_0380);
    chk("int_pc", current_inst_addr_o, 32'h0000_1000);
    chk("int_flush", {31'h0, flush_o}, 32'h1);
    clr(); cp0_status_i = 0; int_i = 0;
    step();
    chk("int_en_drop", {31'h0, cp0_en_o}, 32'h0);
    chk("int_npc_drop", new_pc_o, 32'h0);
    chk("int_type_hold", except_type_o, 32'h1);
    step(); step();

    // Fetch ADEL beats OV
    valid_i = 1; pc_i = 32'hBFC0_0102; inst_adel_i = 1; ov_i = 1; mem_addr_i = 32'h0000_1234;
    step();
    clr();
    chk("adel_en", {31'h0, cp0_en_o}, 32'h1);
    chk("adel_type", except_type_o, 32'h4);
    chk("adel_badv", badvaddr_o, 32'hBFC0_0102);
    step();
    chk("adel_single", {31'h0, cp0_en_o}, 32'h0);

    // Stalled ADES waits in PEND
    valid_i = 1; pc_i = 32'h0000_2000; data_ades_i = 1; mem_addr_i = 32'h8000_0003; stall_i = 1;
    step();
    clr();
    seen = 0;
    step(); if (cp0_en_o) seen++;
    step(); if (cp0_en_o) seen++;
    chk("ades_pend_quiet", seen, 0);
    stall_i = 0;
    step();
    chk("ades_en", {31'h0, cp0_en_o}, 32'h1);
    chk("ades_type", except_type_o, 32'h5);
    chk("ades_badv", badvaddr_o, 32'h8000_0003);
    chk("ades_pc", current_inst_addr_o, 32'h0000_2000);
    step();
    chk("ades_single", {31'h0, cp0_en_o}, 32'h0);
    chk("ades_badv_hold", badvaddr_o, 32'h8000_0003);

    // ERET redirects to EPC
    valid_i = 1; pc_i = 32'h0000_2100; eret_i = 1; cp0_epc_i = 32'hBFC0_1000;
    step();
    clr();
    chk("eret_type", except_type_o, 32'he);
    chk("eret_npc", new_pc_o, 32'hBFC0_1000);
    chk("eret_flush", {31'h0, flush_o}, 32'h1);
    chk("eret_badv", badvaddr_o, 32'h0);
    step();

    // SYSCALL in delay slot, squash shadow, then back-to-back RI
    valid_i = 1; pc_i = 32'h0000_3000; syscall_i = 1; is_in_delayslot_i = 1;
    step();
    clr(); valid_i = 1; ri_i = 1; pc_i = 32'h0000_3004;
    chk("sys_type", except_type_o, 32'h8);
    chk("sys_ds", {31'h0, is_in_delayslot_o}, 32'h1);
    step();
    pc_i = 32'h0000_3008;
    chk("shadow_en", {31'h0, cp0_en_o}, 32'h0);
    chk("shadow_type_hold", except_type_o, 32'h8);
    step();
    clr();
    chk("b2b_en", {31'h0, cp0_en_o}, 32'h1);
    chk("b2b_type", except_type_o, 32'ha);
    chk("b2b_pc", current_inst_addr_o, 32'h0000_3008);
    chk("b2b_ds", {31'h0, is_in_delayslot_o}, 32'h0);
    step();

    // Bubbles never raise the interrupt; next valid instruction does
    cp0_status_i = 32'h0000_0401; int_i = 6'h01;
    seen = 0;
    for (int k = 0; k < 4; k++) begin step(); if (cp0_en_o) seen++; end
    chk("bubble_quiet", seen, 0);
    valid_i = 1; pc_i = 32'h0000_4000;
    step();
    clr(); cp0_status_i = 0; int_i = 0;
    chk("bubble_int_en", {31'h0, cp0_en_o}, 32'h1);
    chk("bubble_int_pc", current_inst_addr_o, 32'h0000_4000);
    step(); step(); step();

    // Reset while in PEND aborts the exception
    valid_i = 1; pc_i = 32'h0000_5000; break_i = 1; stall_i = 1;
    step();
    clr();
    chk("pend_en", {31'h0, cp0_en_o}, 32'h0);
    rst = 1;
    step();
    rst = 0; stall_i = 0;
    chk_all_zero("pend_rst");
    seen = 0;
    for (int k = 0; k < 3; k++) begin step(); if (cp0_en_o) seen++; end
    chk("pend_rst_no_commit", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- MEM-stage exception arbiter for the SRAM pipeline; the producer side of the CP0 exception-commit interface.
- Collects per-instruction exception flags, synchronises and masks hardware interrupts against CP0 Status/Cause, and selects the single highest-priority exception.
- Drives the CP0 commit strobe, exception type, faulting PC, delay-slot flag and BadVAddr to CP0.
- Drives the pipeline flush and the redirect PC to fetch.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, redirect PC for every exception except ERET
SYNC_STAGES, 2, flop depth of the hardware-interrupt synchroniser (at least 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  MEM holds a real (non-bubble) instruction
stall_i  in  1  MEM stalled (SRAM data access outstanding)
pc_i  in  32  PC of the MEM instruction
is_in_delayslot_i  in  1  MEM instruction is in a delay slot
inst_adel_i  in  1  fetch address misaligned
ri_i  in  1  reserved instruction
syscall_i  in  1  SYSCALL
break_i  in  1  BREAK
ov_i  in  1  arithmetic overflow
data_adel_i  in  1  load address misaligned
data_ades_i  in  1  store address misaligned
eret_i  in  1  ERET
mem_addr_i  in  32  data virtual address
int_i  in  6  asynchronous hardware interrupt lines
timer_int_i  in  1  CP0 timer interrupt
cp0_status_i  in  32  current Status
cp0_cause_i  in  32  current Cause
cp0_epc_i  in  32  current EPC
cp0_en_o  out  1  commit strobe to CP0
except_type_o  out  32  EXC_TYPE_* code
current_inst_addr_o  out  32  faulting PC
is_in_delayslot_o  out  1  delay-slot flag to CP0
badvaddr_o  out  32  bad virtual address
flush_o  out  1  flush IF..MEM
new_pc_o  out  32  redirect target

Behaviour:
- Reset: every output is 0, FSM is in IDLE, all synchroniser flops are 0. A reset in any state aborts the pending or committing exception; nothing is committed afterwards.
- Interrupt path:
  - hw = int_i through SYSCALL's-free SYNC_STAGES flop chain, with bit 5 ORed with timer_int_i (timer_int_i is already synchronous and is not passed through the chain).
  - pend = {hw, cp0_cause_i[9:8]} & cp0_status_i[15:8].
  - int_req = |pend & cp0_status_i[0] & ~cp0_status_i[1].
- Detection, combinational: exc = valid_i & (int_req | any exception flag | eret_i).
- Priority: INT > ADEL(fetch) > RI > SYS > BP > OV > ADEL(data) > ADES > ERET.
- badvaddr: pc_i for fetch ADEL; mem_addr_i for data ADEL or ADES; 0 otherwise.
- FSM IDLE:
  - exc & ~stall_i: snapshot type, pc, delay-slot flag and badvaddr; go to COMMIT.
  - exc & stall_i: snapshot the same fields; go to PEND.
- FSM PEND:
  - Hold the snapshot; all inputs are ignored, including a changing int_req.
  - Go to COMMIT on the first cycle with ~stall_i.
- FSM COMMIT:
  - Exactly one cycle with cp0_en_o=1 and flush_o=1; outputs are driven from the snapshot.
  - new_pc_o = cp0_epc_i (sampled this cycle) for ERET, else EXC_VECTOR.
  - valid_i is ignored (squash shadow). Return to IDLE.
- Latency: a non-stalled exception commits in the cycle after detection. A stalled exception commits one cycle after stall_i falls.
- Outside COMMIT: cp0_en_o, flush_o and new_pc_o are 0. except_type_o, current_inst_addr_o, is_in_delayslot_o and badvaddr_o hold their last committed values.
- Bubbles (valid_i=0) never raise an exception, even with int_req set. The interrupt is taken on the next valid instruction.
- Back-to-back: an exception on the instruction entering MEM in the cycle after COMMIT is detected normally.

Decomposition:
- defines.vh holds:
  - EXC_TYPE_INT=32'h1, ADEL=32'h4, ADES=32'h5, SYS=32'h8, BP=32'h9, RI=32'ha, OV=32'hc, ERET=32'he
  - FSM state encodings
  - EXC_VECTOR default
- One sub-module, int_sync: a SYNC_STAGES-deep 6-bit synchroniser with synchronous reset.

Test Plan:
- Status=32'h0000_0401, int_i[0]=1, valid_i=1, no stall -> after SYNC_STAGES+1 cycles, one-cycle cp0_en_o=flush_o=1, except_type_o=32'h1, new_pc_o=32'hBFC0_0380, current_inst_addr_o=pc_i.
- inst_adel_i=1 and ov_i=1 together, pc_i=32'hBFC0_0102 -> except_type_o=32'h4, badvaddr_o=32'hBFC0_0102.
- data_ades_i=1, mem_addr_i=32'h8000_0003, stall_i high for 3 cycles -> PEND; commit exactly 1 cycle after stall_i falls; badvaddr_o=32'h8000_0003; single strobe.
- eret_i=1, cp0_epc_i=32'hBFC0_1000 -> except_type_o=32'he, new_pc_o=32'hBFC0_1000, flush_o=1.
- syscall_i=1 with is_in_delayslot_i=1 -> is_in_delayslot_o=1. The cycle after COMMIT, valid_i with ri_i=1 is ignored while in COMMIT; the next instruction is detected normally.
- rst asserted while in PEND -> no cp0_en_o, all outputs 0, FSM in IDLE.
